// File: rtl/score_bcd_conv_if.sv
// rtl/score_bcd_conv_if.sv - start/ready/done handshake and result bus of the score BCD converter
interface score_bcd_conv_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  // Requester side: score/life logic issuing conversions
  modport master (
    output start, bin_in,
    input  ready, done, bcd_out, overflow
  );

  // Converter side
  modport slave (
    input  start, bin_in,
    output ready, done, bcd_out, overflow
  );
endinterface

// File: rtl/score_bcd_conv.sv
// rtl/score_bcd_conv.sv - sequential double-dabble binary-to-BCD converter with saturation (SCORE_BCD_BLANK_EN enables leading-zero blanking)
module score_bcd_conv #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  score_bcd_conv_if.slave  bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  // Largest displayable value plus one; evaluated at elaboration time.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [ACC_W-1:0] NINES = {DIGITS{4'h9}};

  // Final presentation of a non-saturated result.
  function automatic logic [ACC_W-1:0] present(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] r;
`ifdef SCORE_BCD_BLANK_EN
    logic lead;
    r    = v;
    lead = 1'b1;
    // Units digit is never blanked so zero still shows a single 0.
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
`else
    r = v;
`endif
    return r;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [ACC_W-1:0]      bcd_q, bcd_d;
  logic                  ovfo_q, ovfo_d;

  logic                  ready_s;
  logic                  done_s;
  logic [ACC_W-1:0]      acc_adj;
  logic [ACC_W+BIN_W-1:0] cat_sh;
  logic [ACC_W-1:0]      acc_step;
  logic [BIN_W-1:0]      bin_step;

  // One double-dabble step: add 3 to digits >= 5, then shift {acc, bin} left by one.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    cat_sh   = {acc_adj, bin_q} << 1;
    acc_step = cat_sh[BIN_W +: ACC_W];
    bin_step = cat_sh[BIN_W-1:0];
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    ovfo_d  = ovfo_q;
    ready_s = 1'b1;
    done_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_s = 1'b1;
      end
      S_SHIFT: begin
        ready_s = 1'b0;
        acc_d   = acc_step;
        bin_d   = bin_step;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = ovf_q ? NINES : present(acc_step);
          ovfo_d  = ovf_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ready_s = 1'b1;
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance is identical from IDLE and DONE, allowing back-to-back conversions.
    if (ready_s && bus.start) begin
      bin_d   = bus.bin_in;
      acc_d   = '0;
      cnt_d   = CNT_W'(BIN_W);
      ovf_d   = (64'(bus.bin_in) >= LIMIT);
      state_d = S_SHIFT;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign bus.ready    = ready_s;
  assign bus.done     = done_s;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovfo_q;

endmodule

// File: tb/tb_score_bcd_conv.sv
// tb/tb_score_bcd_conv.sv - self-checking bench for score_bcd_conv against a behavioural decimal model
module tb_score_bcd_conv;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  score_bcd_conv_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  score_bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v computed with division; saturates to all nines.
  function automatic logic [4*DIGITS-1:0] model_bcd(input int unsigned v, output logic ovf);
    logic [4*DIGITS-1:0] r;
    int unsigned lim;
    int unsigned p;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    if (v >= lim) begin
      ovf = 1'b1;
      return {DIGITS{4'h9}};
    end
    ovf = 1'b0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef SCORE_BCD_BLANK_EN
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Model: edges remaining until the result appears; zero means idle/accepting.
  int                  m_rem  = 0;
  int unsigned         m_val  = 0;
  logic                m_done = 1'b0;
  logic [4*DIGITS-1:0] m_bcd  = '0;
  logic                m_ovf  = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_rem = 0;
      m_bcd = '0;
      m_ovf = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_bcd  = model_bcd(m_val, m_ovf);
        m_done = 1'b1;
      end
    end else if (bus.start) begin
      m_rem = BIN_W;
      m_val = int'(bus.bin_in);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",    64'(bus.ready),    64'(m_rem == 0));
      check("done",     64'(bus.done),     64'(m_done));
      check("bcd_out",  64'(bus.bcd_out),  64'(m_bcd));
      check("overflow", 64'(bus.overflow), 64'(m_ovf));
    end
  end

  // Issue one conversion (caller guarantees ready) and wait for done.
  task automatic convert(input int v, output int lat);
    bus.start  = 1'b1;
    bus.bin_in = 10'(v);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = 10'($urandom);
    lat = 1;
    check("ready_low_in_shift", 64'(bus.ready), 64'd0);
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 64'(bus.done), 64'd1);
  endtask

  int lat;
  int done_cnt;
  logic [11:0] exp_zero, exp_38, exp_7;

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
`ifdef SCORE_BCD_BLANK_EN
    exp_zero = 12'hFF0;
    exp_38   = 12'hF38;
    exp_7    = 12'hFF7;
`else
    exp_zero = 12'h000;
    exp_38   = 12'h038;
    exp_7    = 12'h007;
`endif

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready",    64'(bus.ready),    64'd1);
    check("rst_done",     64'(bus.done),     64'd0);
    check("rst_bcd",      64'(bus.bcd_out),  64'h000);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    convert(427, lat);
    check("latency_427", 64'(lat), 64'd11);
    check("bcd_427", 64'(bus.bcd_out), 64'h427);
    check("ovf_427", 64'(bus.overflow), 64'd0);
    @(negedge clk);

    convert(999, lat);
    check("bcd_999", 64'(bus.bcd_out), 64'h999);
    check("ovf_999", 64'(bus.overflow), 64'd0);
    convert(0, lat);
    check("latency_b2b", 64'(lat), 64'd11);
    check("bcd_0", 64'(bus.bcd_out), 64'(exp_zero));
    check("ovf_0", 64'(bus.overflow), 64'd0);
    @(negedge clk);

    convert(1000, lat);
    check("bcd_1000", 64'(bus.bcd_out), 64'h999);
    check("ovf_1000", 64'(bus.overflow), 64'd1);
    @(negedge clk);
    convert(1023, lat);
    check("bcd_1023", 64'(bus.bcd_out), 64'h999);
    check("ovf_1023", 64'(bus.overflow), 64'd1);
    @(negedge clk);

    convert(7, lat);
    check("bcd_7", 64'(bus.bcd_out), 64'(exp_7));
    @(negedge clk);
    convert(205, lat);
    check("bcd_205", 64'(bus.bcd_out), 64'h205);
    @(negedge clk);

    // Reset sampled on the 5th shift edge after acceptance.
    bus.start  = 1'b1;
    bus.bin_in = 10'd555;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("midrst_no_done",  64'(done_cnt),       64'd0);
    check("midrst_bcd",      64'(bus.bcd_out),    64'h000);
    check("midrst_overflow", 64'(bus.overflow),   64'd0);
    check("midrst_ready",    64'(bus.ready),      64'd1);
    convert(38, lat);
    check("bcd_38", 64'(bus.bcd_out), 64'(exp_38));
    @(negedge clk);

    // Random traffic: starts while busy, bin_in churn, rare resets, back-to-back.
    repeat (1500) begin
      bus.start  = ($urandom_range(0, 2) == 0);
      bus.bin_in = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(995, 1023))
                                                : 10'($urandom);
      rst        = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
